// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel valid/ready stream multiplexer with a registered
// output stage. Two arbitration modes: fixed select (mode=0, via sel) and
// round-robin across valid channels (mode=1). Each output beat carries its
// source channel in out_chan.
//
// Optional feature: define STREAM_MUX_COUNT_EN to add the 16-bit saturating
// xfer_count output, which counts output transfers.

// Per-channel slice: qualifies the grant with can_load to form in_ready, and
// masks the channel data so the top level can OR-reduce it into the mux.
module stream_mux_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] lane_data,
  input  logic             lane_gnt,
  input  logic             can_load,
  output logic             lane_ready,
  output logic [WIDTH-1:0] lane_mask
);

  assign lane_ready = lane_gnt & can_load;
  assign lane_mask  = lane_gnt ? lane_data : '0;

endmodule

module stream_mux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef STREAM_MUX_COUNT_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  // With the pointer on the last channel, channel 0 is searched first.
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  // Registered output stage and round-robin pointer
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  // Arbitration results
  logic [CHANNELS-1:0] gnt_oh;
  logic [SEL_W-1:0]    gnt_idx;
  logic                gnt_vld;

  logic                            can_load;
  logic                            in_xfer;
  logic                            out_xfer;
  logic [CHANNELS-1:0][WIDTH-1:0]  lane_mask;
  logic [WIDTH-1:0]                mux_data;

  // The register can take a new beat when empty or when it is being drained
  // this cycle. Reset is folded in so no channel sees ready while held.
  assign can_load = ~reset & (~out_valid_q | out_ready);
  assign out_xfer = out_valid_q & out_ready;
  assign in_xfer  = gnt_vld & can_load;

  // Arbitration: fixed select looks only at in_valid[sel]; round-robin
  // searches from rr_ptr+1 upward with wraparound, first valid channel wins.
  always_comb begin
    int  c;
    logic found;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    found   = 1'b0;
    c       = 0;
    if (!mode) begin
      // An out-of-range sel matches no channel, so nothing is granted.
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_oh[i] = 1'b1;
          gnt_idx   = SEL_W'(i);
          gnt_vld   = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        c = int'(rr_ptr_q) + k;
        if (c >= CHANNELS) c = c - CHANNELS;
        if (!found && in_valid[c]) begin
          found     = 1'b1;
          gnt_oh[c] = 1'b1;
          gnt_idx   = SEL_W'(c);
          gnt_vld   = 1'b1;
        end
      end
    end
  end

  // Per-channel ready generation and data masking
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    stream_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .lane_data  (in_data[i*WIDTH +: WIDTH]),
      .lane_gnt   (gnt_oh[i]),
      .can_load   (can_load),
      .lane_ready (in_ready[i]),
      .lane_mask  (lane_mask[i])
    );
  end

  // AND-OR data mux: at most one lane is unmasked
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) mux_data = mux_data | lane_mask[i];
  end

  // Next-state for the output register and round-robin pointer. A load takes
  // priority over a drain, which gives back-to-back beats at full rate.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (in_xfer) begin
      out_data_d  = mux_data;
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
      if (mode) rr_ptr_d = gnt_idx;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held beat immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= LAST_CH;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifdef STREAM_MUX_COUNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Saturating count of output transfers
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_xfer && xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) xfer_cnt_q <= '0;
    else       xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n (4 channels, 8-bit). Stimulus pushes expected beats
// into a queue from a behavioural arbitration model; a separate monitor pops
// and compares whenever the DUT completes an output transfer.
module tb_stream_mux_n;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic [1:0]     sel;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready;
`ifdef STREAM_MUX_COUNT_EN
  logic [15:0]    xfer_count;
`endif

  stream_mux_n #(.WIDTH(W), .CHANNELS(NCH), .SEL_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_MUX_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  logic [9:0] exp_q[$];     // {chan, data}
  bit         mdl_full = 1'b0;
  int         mdl_ptr  = NCH - 1;
  int         mdl_cnt  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Arbitration rule from the specification; -1 means no grant.
  function automatic int mdl_grant(input bit m, input int s, input bit [NCH-1:0] v, input int ptr);
    if (!m) return (s < NCH && v[s]) ? s : -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (ptr + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check in_ready and record the expected beat at the negedge,
  // then advance the model at the posedge.
  task automatic tick();
    int g;
    bit xfer;
    bit drain;
    logic [NCH-1:0] exp_rdy;
    @(negedge clk);
    exp_rdy = '0;
    xfer    = 1'b0;
    g       = -1;
    if (!reset) begin
      g = mdl_grant(mode, int'(sel), in_valid, mdl_ptr);
      if (g >= 0 && (!mdl_full || out_ready)) begin
        exp_rdy[g] = 1'b1;
        xfer       = 1'b1;
      end
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (xfer) exp_q.push_back({2'(g), in_data[g*W +: W]});
    drain = mdl_full && out_ready;
    @(posedge clk);
    if (reset) begin
      mdl_full = 1'b0;
      mdl_ptr  = NCH - 1;
      mdl_cnt  = 0;
      exp_q.delete();
    end else begin
      if (drain && mdl_cnt < 16'hFFFF) mdl_cnt++;
      if (xfer) begin
        mdl_full = 1'b1;
        if (mode) mdl_ptr = g;
      end else if (drain) begin
        mdl_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_in(input bit m, input logic [1:0] s, input logic [NCH-1:0] v,
                        input logic [NCH*W-1:0] d, input bit ordy);
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
  endtask

  // Monitor: occupancy must follow the model; each output transfer pops one beat.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", 32'(out_valid), 32'(mdl_full));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL beat_unexpected: got chan %0d data %0h expected none", out_chan, out_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_chan", 32'(out_chan), 32'(e[9:8]));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'hF;
    in_data = 32'h13121110; out_ready = 1'b1;
    #1;
    // Reset state with all channels valid
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_in_ready",  32'(in_ready),  0);
    tick(); tick();
    check("rst_out_chan", 32'(out_chan), 0);

    // First beat after reset in round-robin comes from channel 0
    reset = 1'b0;
    #1;
    tick();
    check("first_chan", 32'(out_chan), 0);
    check("first_data", 32'(out_data), 32'h10);

    // Fixed select routing
    set_in(1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1);
    tick();
    set_in(1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1);
    check("m0_in_ready", 32'(in_ready), 32'h4);
    tick();
    check("m0_out_data",  32'(out_data),  32'hA5);
    check("m0_out_chan",  32'(out_chan),  2);
    check("m0_out_valid", 32'(out_valid), 1);

    // Selected channel idle: nothing moves even though others are valid
    set_in(1'b0, 2'd1, 4'b1101, 32'h44332211, 1'b1);
    check("m0_idle_ready", 32'(in_ready), 0);
    tick(); tick();
    check("m0_idle_empty", 32'(out_valid), 0);

    // Round-robin fairness from a fresh reset
    reset = 1'b1; #1; tick(); reset = 1'b0; #1;
    set_in(1'b1, 2'd0, 4'hF, 32'h13121110, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_chan",  32'(out_chan),  32'(k % NCH));
      check("rr_data",  32'(out_data),  32'(8'h10 + (k % NCH)));
      check("rr_valid", 32'(out_valid), 1);
    end

    // Backpressure holds the beat and blocks all inputs
    set_in(1'b0, 2'd0, 4'b0001, 32'h0000003C, 1'b1);
    tick();
    set_in(1'b0, 2'd0, 4'b0001, 32'h0000003D, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", 32'(in_ready), 0);
      tick();
      check("bp_hold_data", 32'(out_data), 32'h3C);
      check("bp_hold_vld",  32'(out_valid), 1);
    end
    out_ready = 1'b1; #1;
    check("bp_refill_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_refill_data", 32'(out_data), 32'h3D);

    // Reset mid-stream drops the held beat at once
    set_in(1'b1, 2'd0, 4'hF, 32'hDDCCBBAA, 1'b0);
    tick();
    reset = 1'b1;
    mdl_full = 1'b0; exp_q.delete();
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    tick();
    reset = 1'b0; #1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic m;
      m = (n % 16 < 8) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 5) == 0) m = ~m;
      set_in(m, 2'($urandom_range(0, 3)), 4'($urandom), $urandom, $urandom_range(0, 3) != 0);
      tick();
    end
    set_in(1'b1, 2'd0, 4'h0, 32'h0, 1'b1);
    repeat (3) tick();
    check("drain_empty", 32'(exp_q.size()), 0);

`ifdef STREAM_MUX_COUNT_EN
    reset = 1'b1; #1; tick(); reset = 1'b0; #1;
    check("cnt_reset", 32'(xfer_count), 0);
    set_in(1'b1, 2'd0, 4'hF, 32'h13121110, 1'b1);
    repeat (6) tick();
    check("cnt_five", 32'(xfer_count), 5);
    check("cnt_model", 32'(xfer_count), 32'(mdl_cnt));
    repeat (65540) tick();
    check("cnt_sat", 32'(xfer_count), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised successor to the team's 2:1 combinational select: an N-channel, W-bit valid/ready stream multiplexer with a registered output stage.
- Two arbitration modes: fixed select, where the sel input chooses the channel, and round-robin across all valid channels.
- Sits between multiple producer streams and a single consumer. Tags each output beat with its source channel.

Parameters:
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, width of sel and out_chan; must satisfy 2**SEL_W >= CHANNELS

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = fixed select via sel; 1 = round-robin
- sel  in  SEL_W  channel index used when mode=0
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready; at most one bit is high
- out_data  out  WIDTH  registered output data
- out_chan  out  SEL_W  source channel of the current out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts the beat

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1. With rr_ptr at CHANNELS-1, channel 0 has first priority.
- can_load = !out_valid | out_ready. This is combinational; a full register may be drained and refilled in the same cycle.
- Grant (combinational) in mode 0:
  - grant = sel if sel < CHANNELS and in_valid[sel]=1; otherwise no grant.
  - sel >= CHANNELS: no grant, and all in_ready bits stay 0.
- Grant (combinational) in mode 1:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo CHANNELS.
  - The first channel with in_valid=1 wins.
- in_ready[g] = can_load when g is the granted channel; all other in_ready bits are 0.
- in_ready must not depend on in_valid of other channels in mode 0. In mode 1, in_ready depends on in_valid as defined by the search.
- Input transfer occurs when in_valid[g] & in_ready[g]. On the next clk edge:
  - out_data <= channel g data
  - out_chan <= g
  - out_valid <= 1
  - if mode=1: rr_ptr <= g
- Output transfer occurs when out_valid & out_ready. If there is no simultaneous input transfer, out_valid <= 0. out_data and out_chan hold their last value.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready stays high.
- Backpressure: while out_valid=1 and out_ready=0, all in_ready bits = 0. out_data, out_chan and out_valid remain stable.
- rr_ptr updates only on an input transfer in mode 1. In mode 0 it holds its value.
- A change of mode or sel takes effect on the next grant. A beat already held in the output register is unaffected.
- No valid inputs: no grant and no change of state, apart from draining the output register.
- Asserting reset mid-stream immediately clears out_valid. The held beat is discarded.

Optional Feature:
- Macro: STREAM_MUX_COUNT_EN.
- When defined:
  - Adds output port xfer_count (out, 16 bits).
  - xfer_count increments on every output transfer and saturates at 16'hFFFF.
  - Reset value is 0.
- When undefined: the port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset with in_valid=4'hF. Required: out_valid=0, out_data=0, in_ready=0 during reset. After release in mode 1, the first beat comes from channel 0.
- Mode 0 routing: sel=2, channel 2 data=8'hA5, in_valid=4'b0100, out_ready=1. Required: in_ready=4'b0100. One cycle later out_data=8'hA5, out_chan=2, out_valid=1.
- Mode 0 with the selected channel idle: sel=1, in_valid=4'b1101. Required: in_ready=0 and no output beat.
- Round-robin fairness: mode=1, in_valid=4'hF held, out_ready=1, channel data 8'h10, 8'h11, 8'h12, 8'h13. Required: out_chan sequence 0,1,2,3,0,… with one beat per cycle.
- Backpressure: hold out_ready=0 for 3 cycles with a beat held (8'h3C). Required: out_data=8'h3C held stable and in_ready=0. With out_ready=1, that beat and the next transfer occur in the same cycle.
- Counter (macro defined): 5 output transfers. Required: xfer_count=5. Preload the counter near saturation via 65540 transfers. Required: xfer_count stays at 16'hFFFF.
